// File: rtl/hdmi_audio_pkg.sv
// Shared helpers for the hdmi audio sampler: NCO width, default sample word type,
// and the mono channel-replication function.
package hdmi_audio_pkg;

  localparam int MAX_WORD_W     = 512;
  localparam int DEF_CHANNELS   = 2;
  localparam int DEF_BIT_WIDTH  = 16;

  typedef logic [MAX_WORD_W-1:0]                   max_word_t;
  typedef logic [DEF_CHANNELS*DEF_BIT_WIDTH-1:0]   sample_word_t;

  function automatic int acc_width(input longint clk_hz);
    return $clog2(clk_hz) + 1;
  endfunction

  // Word is right-aligned; channel 0 sits in the top bit_width bits of the live field.
  function automatic max_word_t mono_replicate(input max_word_t word,
                                               input int channels,
                                               input int bit_width);
    max_word_t mask;
    max_word_t ch0;
    max_word_t res;
    mask = (max_word_t'(1) << bit_width) - max_word_t'(1);
    ch0  = (word >> ((channels - 1) * bit_width)) & mask;
    res  = '0;
    for (int i = 0; i < channels; i++) begin
      res = res | (ch0 << (i * bit_width));
    end
    return res;
  endfunction

endpackage

// File: rtl/hdmi_audio_sampler_fifo.sv
// Synchronous FIFO for the audio sampler; head is read straight from the storage registers.
module hdmi_audio_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Extra MSB on each pointer separates full (MSBs differ) from empty (all equal).
  assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign empty = (r_wr == r_rd);
  assign level = r_wr - r_rd;
  assign dout  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hdmi_audio_sampler.sv
// Audio rate adapter: FIFO-buffered PCM popped by a fractional NCO at AUDIO_RATE from CLK_HZ.
// Define HDMI_AUDIO_STATS_EN to build the saturating underflow/overflow counters.
module hdmi_audio_sampler
  import hdmi_audio_pkg::*;
#(
  parameter int CLK_HZ     = 148_500_000,
  parameter int AUDIO_RATE = 48000,
  parameter int BIT_WIDTH  = 16,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk_pixel,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHANNELS*BIT_WIDTH-1:0]    in_data,
  input  logic                             mono,
  output logic [CHANNELS*BIT_WIDTH-1:0]    audio_sample_word,
  output logic                             sample_strobe,
  output logic                             underflow,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic [15:0]                      underflow_count,
  output logic [15:0]                      overflow_count
);

  localparam int WORD_W = CHANNELS * BIT_WIDTH;
  localparam int ACC_W  = acc_width(CLK_HZ);

  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_sum;
  logic              w_tick;
  logic [WORD_W-1:0] r_word;
  logic              r_strobe;
  logic              r_underflow;
  logic [WORD_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  // acc < CLK_HZ always, so acc + AUDIO_RATE < 2*CLK_HZ fits in ACC_W bits.
  assign w_sum  = r_acc + ACC_W'(AUDIO_RATE);
  assign w_tick = (w_sum >= ACC_W'(CLK_HZ));

  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_pop    = w_tick && !w_empty;

  hdmi_audio_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_pixel),
    .rst   (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (in_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_acc       <= '0;
      r_word      <= '0;
      r_strobe    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_acc       <= w_tick ? (w_sum - ACC_W'(CLK_HZ)) : w_sum;
      r_strobe    <= w_tick;
      r_underflow <= w_tick && w_empty;
      if (w_pop) begin
        r_word <= mono ? WORD_W'(mono_replicate(max_word_t'(w_head), CHANNELS, BIT_WIDTH))
                       : w_head;
      end
    end
  end

  assign audio_sample_word = r_word;
  assign sample_strobe     = r_strobe;
  assign underflow         = r_underflow;

`ifdef HDMI_AUDIO_STATS_EN
  logic [15:0] r_uf_cnt;
  logic [15:0] r_of_cnt;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_uf_cnt <= '0;
      r_of_cnt <= '0;
    end else begin
      if (r_underflow && (r_uf_cnt != 16'hFFFF)) r_uf_cnt <= r_uf_cnt + 16'd1;
      if (in_valid && w_full && (r_of_cnt != 16'hFFFF)) r_of_cnt <= r_of_cnt + 16'd1;
    end
  end

  assign underflow_count = r_uf_cnt;
  assign overflow_count  = r_of_cnt;
`else
  assign underflow_count = '0;
  assign overflow_count  = '0;
`endif

endmodule

// File: tb/tb_hdmi_audio_sampler.sv
// Bench for hdmi_audio_sampler at CLK_HZ=100, AUDIO_RATE=8: queue-based reference model
// compared every cycle, plus directed literal expectations on timing, words and flags.
module tb_hdmi_audio_sampler;

  localparam int CLK_HZ = 100;
  localparam int RATE   = 8;
  localparam int BW     = 16;
  localparam int CH     = 2;
  localparam int DEPTH  = 8;
  localparam int W      = CH * BW;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         mono;
  logic [W-1:0] audio_sample_word;
  logic         sample_strobe;
  logic         underflow;
  logic [3:0]   fifo_level;
  logic [15:0]  underflow_count;
  logic [15:0]  overflow_count;

  int checks = 0;
  int errors = 0;

  hdmi_audio_sampler #(
    .CLK_HZ     (CLK_HZ),
    .AUDIO_RATE (RATE),
    .BIT_WIDTH  (BW),
    .CHANNELS   (CH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_pixel         (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .mono              (mono),
    .audio_sample_word (audio_sample_word),
    .sample_strobe     (sample_strobe),
    .underflow         (underflow),
    .fifo_level        (fifo_level),
    .underflow_count   (underflow_count),
    .overflow_count    (overflow_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: n counts cycles since reset; a tick happens whenever
  // floor(n*RATE/CLK_HZ) advances, which is the exact long-run rate.
  logic [W-1:0] q[$];
  int           n = 0;
  bit           model_ok = 0;
  logic [W-1:0] m_word;
  bit           m_strobe, m_uf;
  int           m_ucnt, m_ocnt;

  task automatic model_step();
    bit tick, full_now, empty_now;
    logic [W-1:0] head;
    if (reset) begin
      q.delete();
      n = 0; m_word = '0; m_strobe = 0; m_uf = 0; m_ucnt = 0; m_ocnt = 0;
      model_ok = 1;
    end else begin
      tick      = (((n + 1) * RATE) / CLK_HZ) != ((n * RATE) / CLK_HZ);
      full_now  = (q.size() == DEPTH);
      empty_now = (q.size() == 0);
      if (m_uf && m_ucnt != 16'hFFFF) m_ucnt++;
      if (in_valid && full_now && m_ocnt != 16'hFFFF) m_ocnt++;
      m_strobe = tick;
      m_uf     = tick && empty_now;
      if (tick && !empty_now) begin
        head   = q.pop_front();
        m_word = mono ? {head[W-1 -: BW], head[W-1 -: BW]} : head;
      end
      if (in_valid && !full_now) q.push_back(in_data);
      n++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("m_level",  64'(fifo_level), 64'(q.size()));
      chk("m_ready",  64'(in_ready), 64'(q.size() != DEPTH));
      chk("m_word",   64'(audio_sample_word), 64'(m_word));
      chk("m_strobe", 64'(sample_strobe), 64'(m_strobe));
      chk("m_uf",     64'(underflow), 64'(m_uf));
`ifdef HDMI_AUDIO_STATS_EN
      chk("m_ucnt",   64'(underflow_count), 64'(m_ucnt));
      chk("m_ocnt",   64'(overflow_count), 64'(m_ocnt));
`else
      chk("m_ucnt0",  64'(underflow_count), 64'd0);
      chk("m_ocnt0",  64'(overflow_count), 64'd0);
`endif
    end
  end

  // Advance to the negedge of cycle c, cycle 1 being the first with reset low.
  task automatic to_cycle(input int c);
    while (n + 1 < c) @(negedge clk);
  endtask

  logic [W-1:0] f [8];
  int           s_cyc [3];
  int           ns, cnt;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    f[0] = 32'h1234_ABCD; f[1] = 32'h1234_ABCD; f[2] = 32'h0003_0003; f[3] = 32'h0004_0004;
    f[4] = 32'h0005_0005; f[5] = 32'h0006_0006; f[6] = 32'h0007_0007; f[7] = 32'h0008_0008;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; mono = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level",  64'(fifo_level), 64'd0);
    chk("rst_word",   64'(audio_sample_word), 64'd0);
    chk("rst_strobe", 64'(sample_strobe), 64'd0);
    chk("rst_uf",     64'(underflow), 64'd0);

    // No input: every strobe is an underflow, word stays 0.
    reset = 1'b0;
    chk("ready_after_rst", 64'(in_ready), 64'd1);
    to_cycle(13);
    chk("no_strobe_c13", 64'(sample_strobe), 64'd0);
    ns = 0; cnt = 0;
    for (int c = 14; c <= 113; c++) begin
      to_cycle(c);
      if (sample_strobe) begin
        cnt++;
        if (ns < 3) begin s_cyc[ns] = c; ns++; end
      end
      if (c == 14) begin
        chk("uf_first_strobe", 64'(sample_strobe), 64'd1);
        chk("uf_first_flag",   64'(underflow), 64'd1);
        chk("uf_word_zero",    64'(audio_sample_word), 64'd0);
      end
`ifdef HDMI_AUDIO_STATS_EN
      if (c == 41) chk("ucnt_3", 64'(underflow_count), 64'd3);
`endif
    end
    chk("strobes_per_100", 64'(cnt), 64'd8);
    chk("first_strobe_cyc", 64'(s_cyc[0]), 64'd14);
    chk("interval_1", 64'(s_cyc[1] - s_cyc[0]), 64'd12);
    chk("interval_2", 64'(s_cyc[2] - s_cyc[1]), 64'd13);

    // Pre-fill to full, hold a 9th frame for 5 cycles, then drain through ticks.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1; in_data = f[0];
    for (int c = 2; c <= 13; c++) begin
      to_cycle(c);
      in_data = (c <= 8) ? f[c-1] : 32'hDEAD_0009;
      if (c == 9) begin
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_level", 64'(fifo_level), 64'd8);
      end
    end
    to_cycle(14);
    in_valid = 1'b0;
    chk("pop_ready",  64'(in_ready), 64'd1);
    chk("pop_level",  64'(fifo_level), 64'd7);
    chk("st_strobe",  64'(sample_strobe), 64'd1);
    chk("st_uf",      64'(underflow), 64'd0);
    chk("st_word",    64'(audio_sample_word), 64'h1234ABCD);
`ifdef HDMI_AUDIO_STATS_EN
    chk("ocnt_5",     64'(overflow_count), 64'd5);
`endif
    mono = 1'b1;
    to_cycle(26);
    chk("mono_strobe", 64'(sample_strobe), 64'd1);
    chk("mono_word",   64'(audio_sample_word), 64'h12341234);
    to_cycle(27);
    mono = 1'b0;
    to_cycle(30);
    chk("mono_held",   64'(audio_sample_word), 64'h12341234);

    // Reset with 4 frames queued and a push attempted in the same cycle.
    to_cycle(55);
    chk("queued_4", 64'(fifo_level), 64'd4);
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hBEEF_BEEF;
    @(negedge clk);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_word",  64'(audio_sample_word), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    reset = 1'b0; in_valid = 1'b0;

    // Push coincident with the first tick on an empty FIFO: underflow, served next tick.
    to_cycle(13);
    in_valid = 1'b1; in_data = 32'hCAFE_0001;
    to_cycle(14);
    in_valid = 1'b0;
    chk("nb_strobe", 64'(sample_strobe), 64'd1);
    chk("nb_uf",     64'(underflow), 64'd1);
    chk("nb_word",   64'(audio_sample_word), 64'd0);
    chk("nb_level",  64'(fifo_level), 64'd1);
    to_cycle(26);
    chk("nb2_strobe", 64'(sample_strobe), 64'd1);
    chk("nb2_uf",     64'(underflow), 64'd0);
    chk("nb2_word",   64'(audio_sample_word), 64'hCAFE0001);
    chk("nb2_level",  64'(fifo_level), 64'd0);
    to_cycle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
